// File: rtl/fc_pkg.sv
// fc_pkg: types and constants shared by the FC input loader and the FC layer.
//   FC_WIDTH   : default bit width of one activation
//   FC_IN      : default activations per frame (the FC fan-in)
//   fc_state_t : loader states
package fc_pkg;

    localparam int FC_WIDTH = 8;
    localparam int FC_IN    = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } fc_state_t;

endpackage

// File: rtl/fc_in_loader.sv
// fc_in_loader: turns a serial stream of activations into the parallel input
// vector of an FC layer. Beats are written in arrival order into an IN-entry
// register array. A complete frame is held on x, with m_valid asserted, until
// the FC layer acknowledges it with m_ready.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst_n    : asynchronous active-low reset
//   s_data   : one activation per accepted beat
//   s_valid  : upstream beat valid
//   s_last   : upstream marks the final beat of a frame
//   s_ready  : loader can accept a beat (IDLE, FILL)
//   x        : parallel activation vector [0:IN-1]
//   m_valid  : x holds a complete frame (HOLD)
//   m_ready  : downstream has consumed x
//   err      : one-cycle pulse when frame length and s_last disagree
//   count    : beats accepted in the current frame
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | empty, x all zero, waiting for the first beat of a frame
// FILL    | collecting beats, count = next entry to write
// HOLD    | frame presented on x, inputs ignored until m_ready
module fc_in_loader
    import fc_pkg::*;
#(
    parameter int WIDTH = FC_WIDTH,
    parameter int IN    = FC_IN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         s_data,
    input  logic                     s_valid,
    input  logic                     s_last,
    output logic                     s_ready,
    output logic [WIDTH-1:0]         x [0:IN-1],
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     err,
    output logic [$clog2(IN+1)-1:0]  count
);

    localparam int CW = $clog2(IN+1);

    fc_state_t        r_state;
    fc_state_t        w_state_nxt;
    logic [CW-1:0]    r_count;
    logic             r_err;
    logic [WIDTH-1:0] r_x [0:IN-1];

    logic             w_accept;
    logic             w_release;
    logic             w_at_last_idx;
    logic             w_frame_end;
    logic             w_len_err;
    logic [IN-1:0]    w_we;

    // count is 0 in IDLE, so it is the write index in both IDLE and FILL.
    assign w_at_last_idx = (r_count == CW'(IN-1));
    assign w_frame_end   = s_last | w_at_last_idx;
    // Error when s_last and the final index disagree: early s_last, or a
    // full frame that arrived without s_last.
    assign w_len_err     = s_last ^ w_at_last_idx;

    assign w_accept  = s_valid & s_ready;
    assign w_release = m_valid & m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    w_state_nxt = w_frame_end ? ST_HOLD : ST_FILL;
                end
            end
            ST_FILL: begin
                s_ready = 1'b1;
                if (s_valid && w_frame_end) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            // Registered so the pulse lines up with the first HOLD cycle.
            r_err <= w_accept & w_len_err;
            if (w_release) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    always_comb begin
        w_we = '0;
        for (int i = 0; i < IN; i++) begin
            w_we[i] = w_accept && (r_count == CW'(i));
        end
    end

    for (genvar gi = 0; gi < IN; gi++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_x[gi] <= '0;
            end else if (w_release) begin
                r_x[gi] <= '0;
            end else if (w_we[gi]) begin
                r_x[gi] <= s_data;
            end
        end
    end

    assign x     = r_x;
    assign err   = r_err;
    assign count = r_count;

endmodule
